csr_scratchpad_responder: RTL
=============================

// Module: csr_scratchpad_responder
// PURPOSE
// - AXI4-Lite CSR responder: the target end of host MMIO reads/writes that unit tests aim at feature DFH/SCRATCHPAD pairs.
// - Holds one read-only DFH word and one read/write 64-bit scratchpad inside a decoded address window.
// - One instance per feature stub (FME, PMCI, PCIe, ST2MM, HSSI, ...), behind the fabric demux.
// PARAMETERS
// - ADDR_W         20              byte-address width
// - BASE_ADDR      20'h20000       window base; aligned to WINDOW_SIZE
// - WINDOW_SIZE    32'h10000       window bytes; power of 2
// - DFH_VALUE      64'h0           value returned at BASE_ADDR+0
// - SCRATCH_OFFSET 20'h8           scratchpad byte offset; 8-byte aligned, nonzero
// - SCRATCH_RESET  64'h0           scratchpad reset value
// PORTS
// - clk      in   1       sole clock
// - rst_n    in   1       async assert, active-low reset
// - awvalid/awready  in/out  1     write address handshake
// - awaddr   in   ADDR_W  write byte address
// - wvalid/wready    in/out  1     write data handshake
// - wdata    in   64      write data
// - wstrb    in   8       byte enables
// - bvalid/bready    out/in  1     write response handshake
// - bresp    out  2       00 OKAY, 10 SLVERR
// - arvalid/arready  in/out  1     read address handshake
// - araddr   in   ADDR_W  read byte address
// - rvalid/rready    out/in  1     read data handshake
// - rdata    out  64      read data
// - rresp    out  2       00 OKAY, 10 SLVERR
// BEHAVIOUR
// - Reset (async, rst_n=0): bvalid=rvalid=0, bresp=rresp=0, rdata=0, AW/W holding flags clear, FSM=IDLE, scratch=SCRATCH_RESET.
//   - Any in-flight transaction is dropped silently.
//   - awready/wready/arready=1 on the first clk after release.
// - Decode:
//   - in_win = (addr & ~(WINDOW_SIZE-1)) == BASE_ADDR.
//   - off = addr & (WINDOW_SIZE-1), with off[2:0] ignored.
//   - off==0 selects DFH. off==SCRATCH_OFFSET selects scratch. Any other in-window offset is a hole.
// - Write capture:
//   - AW and W are accepted independently in any order or cycle.
//   - awready = !aw_held && state!=WR_RESP.
//   - wready = !w_held && state!=WR_RESP.
// - Write commit (state==IDLE, aw_held && w_held), on that edge:
//   - Scratch hit: scratch[8i+:8] <= wdata[8i+:8] for each wstrb[i]=1.
//   - DFH or hole: no state change, bresp=OKAY.
//   - !in_win: bresp=SLVERR.
//   - Then held flags clear, bvalid=1, state=WR_RESP.
//   - Earliest bvalid is 1 cycle after the later of the AW/W handshakes.
// - Read:
//   - arready = state==IDLE && !(aw_held && w_held); a fully captured write always beats a read.
//   - AR handshake on edge N: rvalid=1 at N+1, state=RD_RESP.
//   - rdata = DFH_VALUE, scratch, or 0 for a hole, all with OKAY.
//   - !in_win: rdata=0, SLVERR.
//   - Read-after-write returns the committed value: the commit precedes the AR handshake.
// - FSM: IDLE -> WR_RESP (commit) | RD_RESP (AR handshake).
//   - WR_RESP -> IDLE on bvalid&&bready.
//   - RD_RESP -> IDLE on rvalid&&rready.
//   - Responses hold stable (valid, data, resp) until ready. One transaction outstanding at a time.
// - In RD_RESP, AW/W may still be captured; the commit waits for IDLE.
// - wstrb=0 to scratch: OKAY, no change.
// STRUCTURE
// - Package ofs_csr_resp_pkg:
//   - AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10.
//   - typedef enum {IDLE, WR_RESP, RD_RESP} csr_resp_state_e.
//   - function strb_merge(old, new, strb).
// - Sub-module axil_wr_join: AW/W holding registers and flags, a held-pair output, and a clear input.
// TESTING (BASE_ADDR=20'h20000, SCRATCH_OFFSET=8, DFH_VALUE=64'h3000000010000020)
// - Read 0x20000 -> rdata 64'h3000000010000020, OKAY, rvalid 1 cycle after AR handshake.
// - Write 0x20008 = 64'hDEAD_BEEF_CAFE_F00D, strb FF; read back -> same value, OKAY.
// - W 3 cycles before AW; strb 0F, wdata 64'h1111_1111_2222_2222, over 0 -> read 64'h0000_0000_2222_2222.
// - Write 0x20000 = all ones -> OKAY, DFH read unchanged; read 0x20010 -> 0 OKAY.
// - Read 0x30008 and write 0x10008 -> SLVERR, rdata 0, scratch unchanged.
// - Hold rready=0 for 5 cycles -> rvalid/rdata stable.
//   - AR+complete write same cycle -> write committed first.
//   - rst_n pulse during RD_RESP -> rvalid drops immediately, scratch = SCRATCH_RESET.

Source files
------------

// File: rtl/ofs_csr_resp_pkg.sv
// Shared types and helpers for the CSR scratchpad responder: AXI response
// codes, responder FSM states, address-decode results and byte-strobe merge.
package ofs_csr_resp_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_RESP = 2'd1,
    RD_RESP = 2'd2
  } csr_resp_state_e;

  typedef enum logic [1:0] {
    SEL_DFH     = 2'd0,
    SEL_SCRATCH = 2'd1,
    SEL_HOLE    = 2'd2,
    SEL_MISS    = 2'd3
  } csr_sel_e;

  function automatic logic [63:0] strb_merge(input logic [63:0] old_v,
                                             input logic [63:0] new_v,
                                             input logic [7:0]  strb);
    logic [63:0] merged;
    merged = old_v;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_v[8*i +: 8];
      else         merged[8*i +: 8] = old_v[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axil_wr_join.sv
// Captures the AXI4-Lite AW and W channels independently and presents them
// as one held pair until the responder commits and clears them.
module axil_wr_join
  import ofs_csr_resp_pkg::*;
#(
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_block,
  input  logic              i_clear,
  input  logic              i_awvalid,
  output logic              o_awready,
  input  logic [ADDR_W-1:0] i_awaddr,
  input  logic              i_wvalid,
  output logic              o_wready,
  input  logic [63:0]       i_wdata,
  input  logic [7:0]        i_wstrb,
  output logic              o_pair_valid,
  output logic [ADDR_W-1:0] o_awaddr,
  output logic [63:0]       o_wdata,
  output logic [7:0]        o_wstrb
);

  logic              r_aw_held;
  logic              r_w_held;
  logic [ADDR_W-1:0] r_awaddr;
  logic [63:0]       r_wdata;
  logic [7:0]        r_wstrb;

  assign o_awready    = !r_aw_held && !i_block;
  assign o_wready     = !r_w_held && !i_block;
  assign o_pair_valid = r_aw_held && r_w_held;
  assign o_awaddr     = r_awaddr;
  assign o_wdata      = r_wdata;
  assign o_wstrb      = r_wstrb;

  // Holding registers; a clear only arrives while both halves are held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= {ADDR_W{1'b0}};
      r_wdata   <= 64'h0;
      r_wstrb   <= 8'h0;
    end else if (i_clear) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
    end else begin
      if (i_awvalid && o_awready) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= i_awaddr;
      end
      if (i_wvalid && o_wready) begin
        r_w_held <= 1'b1;
        r_wdata  <= i_wdata;
        r_wstrb  <= i_wstrb;
      end
    end
  end

endmodule

// File: rtl/csr_scratchpad_responder.sv
// AXI4-Lite CSR target holding a read-only DFH word and a byte-writable
// 64-bit scratchpad inside one decoded address window.
module csr_scratchpad_responder
  import ofs_csr_resp_pkg::*;
#(
  parameter int                ADDR_W         = 20,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = 20'h20000,
  parameter logic [31:0]       WINDOW_SIZE    = 32'h10000,
  parameter logic [63:0]       DFH_VALUE      = 64'h0,
  parameter logic [ADDR_W-1:0] SCRATCH_OFFSET = 20'h8,
  parameter logic [63:0]       SCRATCH_RESET  = 64'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_awvalid,
  output logic              o_awready,
  input  logic [ADDR_W-1:0] i_awaddr,
  input  logic              i_wvalid,
  output logic              o_wready,
  input  logic [63:0]       i_wdata,
  input  logic [7:0]        i_wstrb,
  output logic              o_bvalid,
  input  logic              i_bready,
  output logic [1:0]        o_bresp,
  input  logic              i_arvalid,
  output logic              o_arready,
  input  logic [ADDR_W-1:0] i_araddr,
  output logic              o_rvalid,
  input  logic              i_rready,
  output logic [63:0]       o_rdata,
  output logic [1:0]        o_rresp
);

  localparam logic [ADDR_W-1:0] WIN_MASK = ADDR_W'(WINDOW_SIZE - 32'd1);

  csr_resp_state_e   r_state;
  csr_resp_state_e   w_state_nxt;
  logic              w_pair_valid;
  logic [ADDR_W-1:0] w_hold_awaddr;
  logic [63:0]       w_hold_wdata;
  logic [7:0]        w_hold_wstrb;
  logic              w_commit;
  logic              w_ar_hs;
  csr_sel_e          w_wr_sel;
  csr_sel_e          w_rd_sel;
  logic              r_bvalid;
  logic              r_rvalid;
  logic [1:0]        r_bresp;
  logic [1:0]        r_rresp;
  logic [63:0]       r_rdata;
  logic [63:0]       r_scratch;

  function automatic csr_sel_e decode(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off_v;
    off_v        = addr & WIN_MASK;
    off_v[2:0]   = 3'b000;
    if ((addr & ~WIN_MASK) != BASE_ADDR) return SEL_MISS;
    else if (off_v == {ADDR_W{1'b0}})    return SEL_DFH;
    else if (off_v == SCRATCH_OFFSET)    return SEL_SCRATCH;
    else                                 return SEL_HOLE;
  endfunction

  axil_wr_join #(.ADDR_W(ADDR_W)) u_wr_join (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_block      (r_state == WR_RESP),
    .i_clear      (w_commit),
    .i_awvalid    (i_awvalid),
    .o_awready    (o_awready),
    .i_awaddr     (i_awaddr),
    .i_wvalid     (i_wvalid),
    .o_wready     (o_wready),
    .i_wdata      (i_wdata),
    .i_wstrb      (i_wstrb),
    .o_pair_valid (w_pair_valid),
    .o_awaddr     (w_hold_awaddr),
    .o_wdata      (w_hold_wdata),
    .o_wstrb      (w_hold_wstrb)
  );

  // A fully captured write holds off AR, so commit and AR never coincide.
  assign o_arready = (r_state == IDLE) && !w_pair_valid;
  assign w_commit  = (r_state == IDLE) && w_pair_valid;
  assign w_ar_hs   = i_arvalid && o_arready;
  assign w_wr_sel  = decode(w_hold_awaddr);
  assign w_rd_sel  = decode(i_araddr);

  assign o_bvalid = r_bvalid;
  assign o_bresp  = r_bresp;
  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;
  assign o_rresp  = r_rresp;

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_commit)     w_state_nxt = WR_RESP;
        else if (w_ar_hs) w_state_nxt = RD_RESP;
        else              w_state_nxt = IDLE;
      end
      WR_RESP: begin
        if (r_bvalid && i_bready) w_state_nxt = IDLE;
        else                      w_state_nxt = WR_RESP;
      end
      RD_RESP: begin
        if (r_rvalid && i_rready) w_state_nxt = IDLE;
        else                      w_state_nxt = RD_RESP;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Scratchpad storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scratch <= SCRATCH_RESET;
    end else if (w_commit && (w_wr_sel == SEL_SCRATCH)) begin
      r_scratch <= strb_merge(r_scratch, w_hold_wdata, w_hold_wstrb);
    end
  end

  // Response channels; each holds until its ready is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bvalid <= 1'b0;
      r_bresp  <= AXI_RESP_OKAY;
      r_rvalid <= 1'b0;
      r_rresp  <= AXI_RESP_OKAY;
      r_rdata  <= 64'h0;
    end else begin
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= (w_wr_sel == SEL_MISS) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end else if (r_bvalid && i_bready) begin
        r_bvalid <= 1'b0;
      end
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        case (w_rd_sel)
          SEL_DFH: begin
            r_rdata <= DFH_VALUE;
            r_rresp <= AXI_RESP_OKAY;
          end
          SEL_SCRATCH: begin
            r_rdata <= r_scratch;
            r_rresp <= AXI_RESP_OKAY;
          end
          SEL_HOLE: begin
            r_rdata <= 64'h0;
            r_rresp <= AXI_RESP_OKAY;
          end
          default: begin
            r_rdata <= 64'h0;
            r_rresp <= AXI_RESP_SLVERR;
          end
        endcase
      end else if (r_rvalid && i_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

endmodule
